// File: rtl/regxfer_seq_pkg.sv
// Shared definitions for the register-transfer sequencer: FSM state
// encodings and bus-select constants.
package regxfer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_LATCH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam logic BUS1 = 1'b0;
    localparam logic BUS2 = 1'b1;

    // Width of the bus-settle counter; SETTLE is limited to 1..15.
    localparam int CNTW = 4;

endpackage

// File: rtl/regxfer_seq_onehot_dec.sv
// SRCW -> NREG one-hot decoder with enable. An index at or beyond NREG
// decodes to all zeros, so an out-of-range source never drives a bus.
module regxfer_seq_onehot_dec #(
    parameter int NREG = 8,
    parameter int SRCW = 3
) (
    input  logic            en,
    input  logic [SRCW-1:0] idx,
    output logic [NREG-1:0] onehot
);

    // Compare the index against every register position.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            if (en && (idx == SRCW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regxfer_seq.sv
// Register-transfer sequencer. Accepts one transfer or clear command at a
// time and drives per-register OE, latch and clear strobes for the latch
// bank, with bus settle, a single latch pulse and a hold cycle per transfer.
//
// Handshake: cmd_ready is high exactly while the FSM is IDLE. A command is
// taken on the rising edge where cmd_valid && cmd_ready; its fields are
// captured at that edge and may change freely afterwards. There is no
// backpressure on the strobe side.
module regxfer_seq
    import regxfer_seq_pkg::*;
#(
    parameter int NREG   = 8,
    parameter int SRCW   = 3,
    parameter int SETTLE = 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_clr,
    input  logic [SRCW-1:0] cmd_src,
    input  logic            cmd_bus,
    input  logic [NREG-1:0] cmd_dst,
    output logic [NREG-1:0] oe1,
    output logic [NREG-1:0] oe2,
    output logic [NREG-1:0] latch,
    output logic [NREG-1:0] clear,
    output logic            busy,
    output logic            done,
    output logic            err,
    output state_t          dbg_state
);

    localparam logic [CNTW-1:0] SETTLE_M1 = CNTW'(SETTLE - 1);

    function automatic logic src_oor(input logic [SRCW-1:0] s);
        return 32'(s) >= 32'(NREG);
    endfunction

    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;

    logic [SRCW-1:0] src_q;
    logic            bus_q;
    logic [NREG-1:0] dst_q;
    logic            bad_q;

    logic            accept;
    logic [SRCW-1:0] cur_src;
    logic            cur_bus;
    logic [NREG-1:0] cur_dst;
    logic            cur_bad;
    logic [NREG-1:0] src_onehot;

    logic            oe_on;
    logic [NREG-1:0] oe1_n, oe2_n, latch_n, clear_n;
    logic            busy_n, done_n, err_n;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign dbg_state = state;

    // On the accept edge the outputs must already reflect the new command,
    // so the live command fields are used instead of the captured copy.
    assign cur_src = accept ? cmd_src          : src_q;
    assign cur_bus = accept ? cmd_bus          : bus_q;
    assign cur_dst = accept ? cmd_dst          : dst_q;
    assign cur_bad = accept ? src_oor(cmd_src) : bad_q;

    regxfer_seq_onehot_dec #(
        .NREG (NREG),
        .SRCW (SRCW)
    ) u_src_dec (
        .en     (1'b1),
        .idx    (cur_src),
        .onehot (src_onehot)
    );

    // State and settle-counter registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; the settle counter reloads on entry to DRIVE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_clr) begin
                        state_n = ST_CLEAR;
                    end else begin
                        state_n = ST_DRIVE;
                        cnt_n   = SETTLE_M1;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    state_n = ST_LATCH;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_LATCH: state_n = ST_HOLD;
            ST_HOLD:  state_n = ST_IDLE;
            ST_CLEAR: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Capture the command fields on accept.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            src_q <= '0;
            bus_q <= BUS1;
            dst_q <= '0;
            bad_q <= 1'b0;
        end else if (accept) begin
            src_q <= cmd_src;
            bus_q <= cmd_bus;
            dst_q <= cmd_dst;
            bad_q <= src_oor(cmd_src);
        end
    end

    // Strobe values for the coming cycle, derived from the next state.
    always_comb begin
        oe_on   = (state_n == ST_DRIVE) || (state_n == ST_LATCH) ||
                  (state_n == ST_HOLD);
        oe1_n   = (oe_on && cur_bus == BUS1) ? src_onehot : '0;
        oe2_n   = (oe_on && cur_bus == BUS2) ? src_onehot : '0;
        latch_n = (state_n == ST_LATCH && !cur_bad) ? cur_dst : '0;
        clear_n = (state_n == ST_CLEAR) ? cur_dst : '0;
        done_n  = (state_n == ST_HOLD) || (state_n == ST_CLEAR);
        err_n   = (state_n == ST_HOLD) && cur_bad;
        busy_n  = (state_n != ST_IDLE);
    end

    // Output registers, so no input reaches a strobe combinationally and
    // reset drops every strobe at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            oe1   <= '0;
            oe2   <= '0;
            latch <= '0;
            clear <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            oe1   <= oe1_n;
            oe2   <= oe2_n;
            latch <= latch_n;
            clear <= clear_n;
            busy  <= busy_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

endmodule

// File: tb/tb_regxfer_seq.sv
// Bench for regxfer_seq: directed scenarios with literal expectations plus
// randomized commands checked every cycle against a schedule-based model.
module tb_regxfer_seq;
    import regxfer_seq_pkg::*;

    localparam int NREG   = 6;
    localparam int SRCW   = 3;
    localparam int SETTLE = 3;
    localparam int OBS    = 12;

    logic            CLK;
    logic            RESET_N;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_clr;
    logic [SRCW-1:0] cmd_src;
    logic            cmd_bus;
    logic [NREG-1:0] cmd_dst;
    logic [NREG-1:0] oe1, oe2, latch, clear;
    logic            busy, done, err;
    state_t          dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    regxfer_seq #(.NREG(NREG), .SRCW(SRCW), .SETTLE(SETTLE)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_clr   (cmd_clr),
        .cmd_src   (cmd_src),
        .cmd_bus   (cmd_bus),
        .cmd_dst   (cmd_dst),
        .oe1       (oe1),
        .oe2       (oe2),
        .latch     (latch),
        .clear     (clear),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic            ready;
        logic            busy;
        logic [NREG-1:0] oe1;
        logic [NREG-1:0] oe2;
        logic [NREG-1:0] latch;
        logic [NREG-1:0] clear;
        logic            done;
        logic            err;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;

    function automatic rec_t idle_rec();
        rec_t r;
        r = '0;
        r.ready = 1'b1;
        return r;
    endfunction

    // A command expands into the list of per-cycle outputs it produces.
    task automatic push_cmd(input logic clr, input logic [SRCW-1:0] src,
                            input logic bus, input logic [NREG-1:0] dst);
        rec_t r;
        logic [NREG-1:0] ov;
        logic in_range;
        r = '0;
        r.busy = 1'b1;
        if (clr) begin
            r.clear = dst;
            r.done  = 1'b1;
            exp_q.push_back(r);
        end else begin
            in_range = (int'(src) < NREG);
            ov = in_range ? NREG'(1 << src) : '0;
            r.oe1 = bus ? '0 : ov;
            r.oe2 = bus ? ov : '0;
            for (int i = 0; i < SETTLE; i++) exp_q.push_back(r);
            r.latch = in_range ? dst : '0;
            exp_q.push_back(r);
            r.latch = '0;
            r.done  = 1'b1;
            r.err   = !in_range;
            exp_q.push_back(r);
        end
    endtask

    initial cur = idle_rec();

    // Per-cycle compare against the model.
    always @(posedge CLK) begin
        if (!RESET_N) begin
            exp_q.delete();
            cur = idle_rec();
        end else begin
            if (cur.ready && cmd_valid) push_cmd(cmd_clr, cmd_src, cmd_bus, cmd_dst);
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
            #1;
            if (RESET_N) begin
                check("cycle_outputs",
                      64'({cmd_ready, busy, oe1, oe2, latch, clear, done, err}),
                      64'(cur));
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [NREG-1:0] s_oe1 [OBS];
    logic [NREG-1:0] s_oe2 [OBS];
    logic [NREG-1:0] s_lat [OBS];
    logic [NREG-1:0] s_clr [OBS];
    logic            s_done[OBS];
    logic            s_err [OBS];
    logic            s_rdy [OBS];

    // Present a command at a negedge, hold until accepted; returns at the
    // negedge just after the accept edge.
    task automatic send(input logic clr, input logic [SRCW-1:0] src,
                        input logic bus, input logic [NREG-1:0] dst);
        int guard;
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_clr   = clr;
        cmd_src   = src;
        cmd_bus   = bus;
        cmd_dst   = dst;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 50) check("send_timeout", 64'(guard), 64'(0));
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_clr   = 1'($urandom);
        cmd_src   = SRCW'($urandom);
        cmd_bus   = 1'($urandom);
        cmd_dst   = NREG'($urandom);
    endtask

    task automatic observe();
        for (int i = 0; i < OBS; i++) begin
            s_oe1[i]  = oe1;
            s_oe2[i]  = oe2;
            s_lat[i]  = latch;
            s_clr[i]  = clear;
            s_done[i] = done;
            s_err[i]  = err;
            s_rdy[i]  = cmd_ready;
            @(negedge CLK);
        end
    endtask

    // ---------------- main sequence ----------------
    int c_a, c_b, c_c, first_a, first_b, last_a;
    int acc_prev, acc_cnt;

    initial begin
        RESET_N   = 1'b0;
        cmd_valid = 1'b0;
        cmd_clr   = 1'b0;
        cmd_src   = '0;
        cmd_bus   = 1'b0;
        cmd_dst   = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_oe", 64'({oe1, oe2}), 64'(0));
        check("rst_strobes", 64'({latch, clear, busy, done, err}), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("rst_ready", 64'(cmd_ready), 64'(1));

        // Transfer src=2 over bus 1 into register 4.
        send(1'b0, 3'd2, BUS1, 6'h10);
        observe();
        c_a = 0; c_b = 0; c_c = 0; first_a = -1; first_b = -1;
        for (int i = 0; i < OBS; i++) begin
            if (s_oe1[i] == 6'h04) c_a++;
            if (s_oe2[i] != '0) c_c++;
            if (s_lat[i] != '0) begin c_b++; if (first_a < 0) first_a = i; end
            if (s_done[i] && first_b < 0) first_b = i;
        end
        check("xfer_oe1_cycles", 64'(c_a), 64'(5));
        check("xfer_oe2_zero", 64'(c_c), 64'(0));
        check("xfer_latch_cycles", 64'(c_b), 64'(1));
        check("xfer_latch_when", 64'(first_a), 64'(3));
        check("xfer_latch_val", 64'(s_lat[3]), 64'(6'h10));
        check("xfer_done_when", 64'(first_b), 64'(4));

        // Clear every register.
        send(1'b1, 3'd0, BUS1, 6'h3F);
        observe();
        c_a = 0; c_b = 0;
        for (int i = 0; i < OBS; i++) begin
            if (s_clr[i] != '0) c_a++;
            if (!s_rdy[i]) c_b++;
        end
        check("clr_cycles", 64'(c_a), 64'(1));
        check("clr_val", 64'({s_clr[0], s_done[0]}), 64'({6'h3F, 1'b1}));
        check("clr_ready_low", 64'(c_b), 64'(1));

        // Out-of-range source.
        send(1'b0, 3'd7, BUS2, 6'h0C);
        observe();
        c_a = 0; c_b = 0;
        for (int i = 0; i < OBS; i++) begin
            if ((s_oe1[i] | s_oe2[i] | s_lat[i]) != '0) c_a++;
            if (s_err[i]) c_b++;
        end
        check("oor_no_strobes", 64'(c_a), 64'(0));
        check("oor_err_cycles", 64'(c_b), 64'(1));
        check("oor_err_done", 64'({s_err[4], s_done[4]}), 64'(2'b11));

        // Self-transfer over bus 2.
        send(1'b0, 3'd5, BUS2, 6'b100001);
        observe();
        c_a = 0; last_a = -1; c_c = 0;
        for (int i = 0; i < OBS; i++) begin
            if (s_oe2[i] == 6'h20) begin c_a++; last_a = i; end
            if (s_oe1[i] != '0) c_c++;
        end
        check("self_oe2_cycles", 64'(c_a), 64'(5));
        check("self_oe2_thru_hold", 64'({last_a[7:0], s_done[4]}), 64'({8'd4, 1'b1}));
        check("self_latch", 64'(s_lat[3]), 64'(6'h21));
        check("self_oe1_zero", 64'(c_c), 64'(0));

        // Reset asserted during LATCH.
        send(1'b0, 3'd1, BUS1, 6'h02);
        repeat (3) @(negedge CLK);
        check("rst_mid_latch_pre", 64'(latch), 64'(6'h02));
        #1;
        RESET_N = 1'b0;
        #1;
        check("rst_mid_strobes", 64'({oe1, oe2, latch, clear}), 64'(0));
        check("rst_mid_flags", 64'({busy, done, err}), 64'(0));
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        observe();
        c_a = 0;
        for (int i = 0; i < OBS; i++) if (s_done[i]) c_a++;
        check("rst_mid_no_done", 64'(c_a), 64'(0));
        check("rst_mid_ready", 64'(s_rdy[0]), 64'(1));

        // Back-to-back transfers with cmd_valid held high.
        acc_prev = -1;
        acc_cnt  = 0;
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_clr   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cmd_src = SRCW'($urandom_range(0, NREG - 1));
            cmd_bus = 1'($urandom);
            cmd_dst = NREG'($urandom);
            if (cmd_ready) begin
                check("b2b_turnaround", 64'(oe1 | oe2), 64'(0));
                if (acc_prev >= 0) check("b2b_spacing", 64'(cyc - acc_prev), 64'(SETTLE + 3));
                acc_prev = cyc;
                acc_cnt++;
            end
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", 64'(acc_cnt >= 6), 64'(1));

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            cmd_valid = ($urandom_range(0, 99) < 45);
            cmd_clr   = ($urandom_range(0, 99) < 30);
            cmd_src   = SRCW'($urandom_range(0, (1 << SRCW) - 1));
            cmd_bus   = 1'($urandom);
            cmd_dst   = NREG'($urandom);
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
        repeat (SETTLE + 6) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
